// File: rtl/up_bus_arb.sv
// up_bus_arb: round-robin two-master arbiter with m1 lock, driving the ha1588 register port.
module up_bus_arb #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [7:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [7:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        wr_out,
  output logic        rd_out,
  output logic [7:0]  addr_out,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3;
  logic [1:0] state, cnt;
  logic       last_grant, m1_owner, win, lat_wr;
  logic       g0, g1, pick;
  // m1_owner tracks whether m1 actually holds the bus, so lock only bites after an m1 grant
  assign g0   = m0_req && !(m1_lock && m1_owner);
  assign g1   = m1_req;
  assign pick = (g0 && g1) ? !last_grant : g1;
  assign wr_out = (state == ISSUE) && lat_wr;
  assign rd_out = (state == ISSUE) && !lat_wr;
  assign m0_ack = (state == ACK) && !win;
  assign m1_ack = (state == ACK) && win;
  assign busy   = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      m1_owner   <= 1'b0;
      win        <= 1'b0;
      lat_wr     <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (g0 || g1) begin
          win        <= pick;
          last_grant <= pick;
          m1_owner   <= pick;
          lat_wr     <= pick ? m1_wr : m0_wr;
          addr_out   <= pick ? m1_addr : m0_addr;
          data_out   <= pick ? m1_wdata : m0_wdata;
          state      <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= lat_wr ? ACK : WAIT;
        end
        WAIT: if (cnt == 2'(RD_LATENCY - 1)) begin
          if (win) m1_rdata <= data_in;
          else m0_rdata <= data_in;
          state <= ACK;
        end else cnt <= cnt + 2'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_up_bus_arb.sv
// tb_up_bus_arb: directed table-driven checks of up_bus_arb at read latency 1 and 4.
module tb_up_bus_arb;
  logic        clk, rst_n;
  logic        m0_req, m0_wr, m1_req, m1_wr, m1_lock, q0, q1;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, data_in;
  logic        m0_ack, m1_ack, wr_out, rd_out, busy;
  logic [31:0] m0_rdata, m1_rdata, data_out;
  logic [7:0]  addr_out;
  logic        b_m0_ack, b_m1_ack, b_wr_out, b_rd_out, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_data_out;
  logic [7:0]  b_addr_out;
  int passed = 0, total = 0;
  logic [31:0] shadow [2];
  typedef struct {
    logic        port;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          lat;
  } vec_t;
  vec_t tv [6];

  up_bus_arb #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out), .data_out(data_out),
    .data_in(data_in), .busy(busy));

  up_bus_arb #(.RD_LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(q0), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(q1), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .wr_out(b_wr_out), .rd_out(b_rd_out), .addr_out(b_addr_out), .data_out(b_data_out),
    .data_in(data_in), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    if (v.port) begin
      m1_req = 1'b1; m1_wr = v.wr; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_wr = v.wr; m0_addr = v.addr; m0_wdata = v.wdata;
    end
    chk("grant_idle", 32'(busy), 32'd0);
    step();
    chk("wr_strobe", 32'(wr_out), 32'(v.wr));
    chk("rd_strobe", 32'(rd_out), 32'(!v.wr));
    chk("addr_out", 32'(addr_out), 32'(v.addr));
    chk("data_out", data_out, v.wdata);
    data_in = 32'hdead_beef;
    for (int c = 2; c <= v.lat; c++) begin
      step();
      data_in = (c == 2) ? v.din : 32'hdead_beef;
      chk("win_ack", 32'(v.port ? m1_ack : m0_ack), 32'(c == v.lat));
      chk("lose_ack", 32'(v.port ? m0_ack : m1_ack), 32'd0);
      chk("strobe_idle", 32'({wr_out, rd_out}), 32'd0);
    end
    if (!v.wr) shadow[v.port] = v.din;
    chk("win_rdata", v.port ? m1_rdata : m0_rdata, shadow[v.port]);
    chk("lose_rdata", v.port ? m0_rdata : m1_rdata, shadow[!v.port]);
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    chk("back_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    tv[0] = '{1'b0, 1'b1, 8'h10, 32'h0000_0008, 32'h0,         2};
    tv[1] = '{1'b1, 1'b0, 8'h24, 32'h0,         32'h1234_5678, 3};
    tv[2] = '{1'b0, 1'b0, 8'h3c, 32'h0000_0077, 32'hcafe_0001, 3};
    tv[3] = '{1'b1, 1'b1, 8'h7f, 32'hffff_ffff, 32'h0,         2};
    tv[4] = '{1'b0, 1'b1, 8'h00, 32'h0000_5a5a, 32'h0,         2};
    tv[5] = '{1'b1, 1'b0, 8'hff, 32'h0,         32'h8000_0001, 3};
    shadow[0] = '0;
    shadow[1] = '0;
    rst_n = 1'b0;
    {m0_req, m0_wr, m1_req, m1_wr, m1_lock, q0, q1} = '0;
    {m0_addr, m1_addr} = '0;
    {m0_wdata, m1_wdata} = '0;
    m0_wdata = 32'h1; m1_wdata = 32'h2; m0_addr = 8'h3; m1_addr = 8'h4;
    data_in = 32'hffff_ffff;
    #12;
    chk("rst_ctrl", 32'({m0_ack, m1_ack, wr_out, rd_out, busy}), 32'd0);
    chk("rst_addr", 32'(addr_out), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    chk("rst_busy4", 32'(b_busy), 32'd0);
    do_reset();
    foreach (tv[i]) run_txn(tv[i]);

    // both masters writing continuously: m0 first, then strict alternation every 3 cycles
    rst_n = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h01;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h02;
    step();
    rst_n = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      chk("rr_m0_ack", 32'(m0_ack), 32'(c == 2 || c == 8));
      chk("rr_m1_ack", 32'(m1_ack), 32'(c == 5 || c == 11));
      if (c == 1 || c == 4) chk("rr_addr", 32'(addr_out), (c == 1) ? 32'h01 : 32'h02);
      step();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;

    // lock held by m1 blocks m0 until released
    do_reset();
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h40; m1_lock = 1'b1;
    step();
    step();
    chk("lock_m1_ack", 32'(m1_ack), 32'd1);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h41;
    for (int c = 3; c <= 7; c++) begin
      step();
      chk("lock_hold_busy", 32'(busy), 32'd0);
      chk("lock_hold_ack", 32'(m0_ack), 32'd0);
    end
    m1_lock = 1'b0;
    step();
    chk("unlock_issue", 32'({busy, wr_out}), 32'd3);
    chk("unlock_addr", 32'(addr_out), 32'h41);
    step();
    chk("unlock_m0_ack", 32'(m0_ack), 32'd1);
    m1_lock = 1'b1;
    step();
    step();
    step();
    chk("lock_no_owner", 32'(m0_ack), 32'd1);
    m0_req = 1'b0;
    m1_lock = 1'b0;
    step();

    // reset during read WAIT aborts; m0 wins the next contention
    do_reset();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h55;
    step();
    step();
    data_in = 32'h1111_2222;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", 32'({busy, wr_out, rd_out, m0_ack, m1_ack}), 32'd0);
    chk("abort_rdata", m1_rdata, 32'd0);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h66;
    m1_wr = 1'b1;
    step();
    chk("abort_no_ack", 32'(m1_ack), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_m0_ack", 32'(m0_ack), 32'd1);
    chk("post_rst_m1_ack", 32'(m1_ack), 32'd0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    step();
    step();
    step();

    // RD_LATENCY=4: ack 6 cycles after grant, data sampled 4 cycles after rd_out
    do_reset();
    q0 = 1'b1; m0_wr = 1'b0; m0_addr = 8'h33; data_in = 32'ha000_0000;
    step();
    chk("l4_rd_out", 32'(b_rd_out), 32'd1);
    chk("l4_addr", 32'(b_addr_out), 32'h33);
    for (int c = 2; c <= 6; c++) begin
      step();
      data_in = 32'ha000_0000 + 32'(c);
      chk("l4_ack", 32'(b_m0_ack), 32'(c == 6));
    end
    chk("l4_rdata", b_m0_rdata, 32'ha000_0005);
    chk("l4_m1_rdata", b_m1_rdata, 32'd0);
    q0 = 1'b0;
    step();
    chk("l4_idle", 32'(b_busy), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
